// File: rtl/ae_defs.sv
// Shared autoencoder control-path definitions: opcodes, sequencer states and
// default instruction field layout.
package ae_defs;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned ADDR_W = 8;

    localparam logic [OP_W-1:0] OP_ADD    = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB    = 4'b0001;
    localparam logic [OP_W-1:0] OP_MUL    = 4'b0010;
    localparam logic [OP_W-1:0] OP_MEMW   = 4'b0011;
    localparam logic [OP_W-1:0] OP_MEMSEL = 4'b0100;
    localparam logic [OP_W-1:0] OP_SIG    = 4'b0101;
    localparam logic [OP_W-1:0] OP_RELU   = 4'b0110;
    localparam logic [OP_W-1:0] OP_DSIG   = 4'b0111;
    localparam logic [OP_W-1:0] OP_HALT   = 4'b1110;
    localparam logic [OP_W-1:0] OP_NOP    = 4'b1111;

    // Field LSB offsets for the default word layout (opcode MSB first)
    localparam int unsigned FLD_B_LSB  = 0;
    localparam int unsigned FLD_A_LSB  = ADDR_W;
    localparam int unsigned FLD_D_LSB  = 2 * ADDR_W;
    localparam int unsigned FLD_OP_LSB = 3 * ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPTURE,
        ST_ISSUE,
        ST_DONE
    } seq_state_e;

endpackage

// File: rtl/instr_seq.sv
// Instruction sequencer: fetches words from a synchronous ROM, splits them into
// opcode plus three addresses and issues them one at a time to the control unit.
module instr_seq
    import ae_defs::*;
#(
    parameter int unsigned OP_WIDTH    = 4,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned PC_WIDTH    = 8,
    parameter int unsigned INSTR_WIDTH = OP_WIDTH + 3 * ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stall,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [OP_WIDTH-1:0]    opcode,
    output logic [ADDR_WIDTH-1:0]  addr_d,
    output logic [ADDR_WIDTH-1:0]  addr_a,
    output logic [ADDR_WIDTH-1:0]  addr_b,
    output logic                   instr_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int unsigned OP_LSB = 3 * ADDR_WIDTH;
    localparam int unsigned D_LSB  = 2 * ADDR_WIDTH;
    localparam int unsigned A_LSB  = ADDR_WIDTH;
    localparam logic [OP_WIDTH-1:0] HALT = OP_WIDTH'(OP_HALT);
    localparam logic [OP_WIDTH-1:0] NOP  = OP_WIDTH'(OP_NOP);

    seq_state_e state, state_nxt;

    logic [PC_WIDTH-1:0]   pc, pc_nxt;
    logic                  err_nxt;
    logic [OP_WIDTH-1:0]   opcode_nxt;
    logic [ADDR_WIDTH-1:0] addr_d_nxt, addr_a_nxt, addr_b_nxt;
    logic [OP_WIDTH-1:0]   rd_op;

    assign rd_op     = imem_rdata[OP_LSB +: OP_WIDTH];
    assign imem_addr = pc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-register values
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        err_nxt    = err;
        opcode_nxt = opcode;
        addr_d_nxt = addr_d;
        addr_a_nxt = addr_a;
        addr_b_nxt = addr_b;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    pc_nxt    = '0;
                    err_nxt   = 1'b0;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // HALT is consumed here and never reaches the outputs
                if (rd_op == HALT) begin
                    state_nxt = ST_DONE;
                end else begin
                    opcode_nxt = rd_op;
                    addr_d_nxt = imem_rdata[D_LSB +: ADDR_WIDTH];
                    addr_a_nxt = imem_rdata[A_LSB +: ADDR_WIDTH];
                    addr_b_nxt = imem_rdata[0 +: ADDR_WIDTH];
                    state_nxt  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!stall) begin
                    opcode_nxt = NOP;
                    // Last address without HALT: flag overflow instead of wrapping
                    if (pc == '1) begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        pc_nxt    = pc + PC_WIDTH'(1);
                        state_nxt = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered status outputs, derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= '0;
            err         <= 1'b0;
            opcode      <= NOP;
            addr_d      <= '0;
            addr_a      <= '0;
            addr_b      <= '0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            pc          <= pc_nxt;
            err         <= err_nxt;
            opcode      <= opcode_nxt;
            addr_d      <= addr_d_nxt;
            addr_a      <= addr_a_nxt;
            addr_b      <= addr_b_nxt;
            instr_valid <= (state_nxt == ST_ISSUE);
            busy        <= (state_nxt == ST_FETCH) || (state_nxt == ST_CAPTURE)
                           || (state_nxt == ST_ISSUE);
            done        <= (state_nxt == ST_DONE);
        end
    end

endmodule

// File: tb/tb_instr_seq.sv
// Directed scoreboard bench for instr_seq: default-width instance plus a
// PC_WIDTH=2 instance for overflow and last-address HALT.
module tb_instr_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Default instance
    logic        start1, stall1;
    logic [7:0]  addr1;
    logic [27:0] rdata1;
    logic [3:0]  op1;
    logic [7:0]  d1, a1, b1;
    logic        v1, busy1, done1, err1;
    logic [27:0] rom1 [256];

    // PC_WIDTH=2 instance
    logic        start2, stall2;
    logic [1:0]  addr2;
    logic [27:0] rdata2;
    logic [3:0]  op2;
    logic [7:0]  d2, a2, b2;
    logic        v2, busy2, done2, err2;
    logic [27:0] rom2 [4];

    always @(posedge clk) rdata1 <= rom1[addr1];
    always @(posedge clk) rdata2 <= rom2[addr2];

    instr_seq u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .stall(stall1),
        .imem_addr(addr1), .imem_rdata(rdata1), .opcode(op1),
        .addr_d(d1), .addr_a(a1), .addr_b(b1), .instr_valid(v1),
        .busy(busy1), .done(done1), .err(err1)
    );

    instr_seq #(.PC_WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .stall(stall2),
        .imem_addr(addr2), .imem_rdata(rdata2), .opcode(op2),
        .addr_d(d2), .addr_a(a2), .addr_b(b2), .instr_valid(v2),
        .busy(busy2), .done(done2), .err(err2)
    );

    typedef struct {
        int         cyc;
        logic [3:0] op;
        logic [7:0] d, a, b;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    logic prev_v = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_exp(input int c, input logic [3:0] op,
                            input logic [7:0] d, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.cyc = c; e.op = op; e.d = d; e.a = a; e.b = b;
        exp_q.push_back(e);
    endtask

    // Scoreboard pop on the first cycle of every ISSUE
    task automatic observe(input logic v, input logic [3:0] op,
                           input logic [7:0] d, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        if (v && !prev_v) begin
            check("issue_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("issue_cycle", 32'(cyc), 32'(e.cyc));
                check("issue_opcode", 32'(op), 32'(e.op));
                check("issue_addr_d", 32'(d), 32'(e.d));
                check("issue_addr_a", 32'(a), 32'(e.a));
                check("issue_addr_b", 32'(b), 32'(e.b));
            end
        end
        if (!v) check("nop_when_invalid", 32'(op), 32'hF);
        prev_v = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Program 1 on the default instance: optional stall window and ignored start pulses
    task automatic run1(input int s_lo, input int s_hi, input bit pulses, input int done_exp);
        int done_seen;
        int done_cyc;
        done_seen = 0;
        done_cyc  = -1;
        prev_v    = 1'b0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        cyc    = 1;
        for (int i = 0; i < 16; i++) begin
            stall1 = (cyc >= s_lo) && (cyc <= s_hi);
            start1 = pulses && (cyc == 4 || cyc == 9);
            observe(v1, op1, d1, a1, b1);
            if (done1) begin
                done_seen++;
                done_cyc = cyc;
            end
            if (s_lo > 0 && cyc >= 3 && cyc <= 6) begin
                check("stall_valid", 32'(v1), 32'd1);
                check("stall_opcode", 32'(op1), 32'h0);
                check("stall_addr_d", 32'(d1), 32'h01);
                check("stall_imem_addr", 32'(addr1), 32'h0);
            end
            if (cyc >= done_exp) check("busy_after_done", 32'(busy1), 32'd0);
            else if (cyc >= 1) check("busy_during_run", 32'(busy1), 32'd1);
            tick();
        end
        stall1 = 1'b0;
        start1 = 1'b0;
        check("done_count", 32'(done_seen), 32'd1);
        check("done_cycle", 32'(done_cyc), 32'(done_exp));
        check("issues_left", 32'(exp_q.size()), 32'd0);
        check("err_after_halt", 32'(err1), 32'd0);
    endtask

    // PC_WIDTH=2 instance run; err must be clear until the done pulse
    task automatic run2(input int done_exp, input logic err_exp);
        int done_seen;
        int done_cyc;
        done_seen = 0;
        done_cyc  = -1;
        prev_v    = 1'b0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        cyc    = 1;
        for (int i = 0; i < 16; i++) begin
            observe(v2, op2, d2, a2, b2);
            if (done2) begin
                done_seen++;
                done_cyc = cyc;
            end
            if (cyc < done_exp) check("err_before_done", 32'(err2), 32'd0);
            else check("err_final", 32'(err2), 32'(err_exp));
            tick();
        end
        check("done2_count", 32'(done_seen), 32'd1);
        check("done2_cycle", 32'(done_cyc), 32'(done_exp));
        check("issues2_left", 32'(exp_q.size()), 32'd0);
        check("pc2_no_wrap_busy", 32'(busy2), 32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        start1 = 1'b0; stall1 = 1'b0;
        start2 = 1'b0; stall2 = 1'b0;
        for (int i = 0; i < 256; i++) rom1[i] = 28'hE000000;
        rom1[0] = 28'h0010203;
        rom1[1] = 28'h2040506;
        rom1[2] = 28'hE000000;
        rom2[0] = 28'h0112233;
        rom2[1] = 28'h1445566;
        rom2[2] = 28'h5778899;
        rom2[3] = 28'h7AABBCC;

        // Reset state
        tick();
        tick();
        check("rst_valid", 32'(v1), 32'd0);
        check("rst_opcode", 32'(op1), 32'hF);
        check("rst_addr_d", 32'(d1), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_err", 32'(err1), 32'd0);
        check("rst_imem_addr", 32'(addr1), 32'd0);
        #3 rst_n = 1'b1;
        tick();

        // Plain program
        push_exp(3, 4'h0, 8'h01, 8'h02, 8'h03);
        push_exp(6, 4'h2, 8'h04, 8'h05, 8'h06);
        run1(0, -1, 1'b0, 9);

        // Stalled first instruction
        push_exp(3, 4'h0, 8'h01, 8'h02, 8'h03);
        push_exp(9, 4'h2, 8'h04, 8'h05, 8'h06);
        run1(3, 5, 1'b0, 12);

        // start pulses in FETCH and DONE are ignored
        push_exp(3, 4'h0, 8'h01, 8'h02, 8'h03);
        push_exp(6, 4'h2, 8'h04, 8'h05, 8'h06);
        run1(0, -1, 1'b1, 9);

        // PC overflow without HALT, then HALT at the last address
        push_exp(3,  4'h0, 8'h11, 8'h22, 8'h33);
        push_exp(6,  4'h1, 8'h44, 8'h55, 8'h66);
        push_exp(9,  4'h5, 8'h77, 8'h88, 8'h99);
        push_exp(12, 4'h7, 8'hAA, 8'hBB, 8'hCC);
        run2(13, 1'b1);
        check("err_sticky_idle", 32'(err2), 32'd1);
        rom2[3] = 28'hE000000;
        push_exp(3, 4'h0, 8'h11, 8'h22, 8'h33);
        push_exp(6, 4'h1, 8'h44, 8'h55, 8'h66);
        push_exp(9, 4'h5, 8'h77, 8'h88, 8'h99);
        run2(12, 1'b0);

        // Asynchronous reset mid-run, while the second instruction is issuing
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        cyc    = 1;
        while (cyc < 6) tick();
        check("pre_rst_valid", 32'(v1), 32'd1);
        check("pre_rst_imem_addr", 32'(addr1), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(v1), 32'd0);
        check("async_rst_opcode", 32'(op1), 32'hF);
        check("async_rst_busy", 32'(busy1), 32'd0);
        check("async_rst_imem_addr", 32'(addr1), 32'd0);
        check("async_rst_err", 32'(err1), 32'd0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_reissue_valid", 32'(v1), 32'd0);
            check("no_reissue_busy", 32'(busy1), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_seq.md
# instr_seq

Instruction sequencer for the autoencoder control path, sitting directly upstream of the control unit. On `start` it fetches instruction words from a synchronous-read instruction ROM and splits each word into a 4-bit opcode plus three operand addresses. It presents one instruction at a time to the control unit and datapath, holding it while `stall` is high. It stops on a HALT opcode or on program-counter overflow.

## Interface
Parameters:
- `OP_WIDTH`, 4, opcode width; must match the control unit.
- `ADDR_WIDTH`, 8, width of each operand/destination address.
- `PC_WIDTH`, 8, program counter width; ROM depth is 2^PC_WIDTH.
- `INSTR_WIDTH`, OP_WIDTH+3*ADDR_WIDTH (28), instruction word width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous assertion, active-low.
- `start`  in  1  begin program at PC 0; sampled only in IDLE.
- `stall`  in  1  downstream busy; holds the current ISSUE.
- `imem_addr`  out  PC_WIDTH  ROM address; equals the `pc` register.
- `imem_rdata`  in  INSTR_WIDTH  ROM data, valid one cycle after the address.
- `opcode`  out  OP_WIDTH  to the control unit; NOP (4'b1111) whenever `instr_valid`=0.
- `addr_d` / `addr_a` / `addr_b`  out  ADDR_WIDTH each  destination / source A / source B addresses.
- `instr_valid`  out  1  high in ISSUE only.
- `busy`  out  1  high in FETCH, CAPTURE and ISSUE.
- `done`  out  1  one-cycle pulse at end of program.
- `err`  out  1  sticky; PC overflow without HALT; cleared by an accepted `start`.

## Operation
- Instruction word layout: [27:24] opcode, [23:16] addr_d, [15:8] addr_a, [7:0] addr_b. Fields are generalised by the parameters, MSB first.
- Opcodes 0000–0111 and 1111 pass through unchanged. 1110 = HALT, consumed here and never issued. 1000–1101 pass through; the control unit treats them as don't-care.

State machine states: IDLE, FETCH, CAPTURE, ISSUE, DONE.
- IDLE: `start`=1 → pc←0, err←0, go to FETCH.
- FETCH: drive `imem_addr`=pc; go to CAPTURE.
- CAPTURE: `imem_rdata` is valid.
  - Opcode==HALT → go to DONE.
  - Otherwise → instruction register ←`imem_rdata`, go to ISSUE.
- ISSUE: outputs are driven from the instruction register and `instr_valid`=1.
  - `stall`=1 → stay, all outputs stable.
  - `stall`=0 and pc==all-ones → err←1, go to DONE.
  - Otherwise → pc←pc+1, go to FETCH.
- DONE: `done`=1 for this cycle only; go to IDLE unconditionally.

Boundary rules:
- `start` outside IDLE is ignored, including during DONE.
- `stall` outside ISSUE is ignored.
- HALT at address 2^PC_WIDTH−1 is a normal halt; err stays 0.
- pc never wraps silently.
- `rst_n` low at any time → immediate return to IDLE with all reset values applied. An in-flight instruction is dropped and never reissued.

Reset values:
- pc / `imem_addr` = 0.
- `opcode` = 4'b1111.
- `addr_*` = 0.
- `instr_valid`, `busy`, `done`, `err` = 0.

## Timing
- `start` sampled high at edge N → FETCH in cycle N+1, CAPTURE in N+2, ISSUE (`instr_valid`=1) in N+3.
- Unstalled throughput: one instruction per 3 cycles.
- Each stall cycle in ISSUE adds one cycle. The next FETCH follows the first ISSUE cycle with `stall`=0.
- HALT fetched at FETCH cycle F → DONE (`done`=1) at F+2, IDLE at F+3.
- All outputs are registered or decoded from state only; no input-to-output combinational path.
- `imem_addr` changes only on a clock edge.

## Structure
- The shared package `ae_defs` holds:
  - opcode constants: OP_ADD 0000, OP_SUB 0001, OP_MUL 0010, OP_MEMW 0011, OP_MEMSEL 0100, OP_SIG 0101, OP_RELU 0110, OP_DSIG 0111, OP_HALT 1110, OP_NOP 1111;
  - the state encoding;
  - instruction field offsets.
- The control unit uses the same opcode constants.
- Single module; no sub-module. The PC counter and field split are inline.

## Test plan
- Reset: assert `rst_n`=0 mid-run → same cycle `instr_valid`=0, `opcode`=1111, `busy`=0, `imem_addr`=0, `err`=0.
- ROM {0:0x0010203, 1:0x2040506, 2:0xE000000}, `start` at edge 0:
  - `instr_valid` in cycle 3 with opcode 0000, addr_d 01, addr_a 02, addr_b 03;
  - `instr_valid` in cycle 6 with opcode 0010, 04/05/06;
  - `done` in cycle 9, `busy` low from cycle 9;
  - HALT is never issued.
- Stall: same program, `stall`=1 during cycles 3–5 → first instruction held with stable outputs in cycles 3–6, second ISSUE in cycle 9, `imem_addr` stays 0 through cycle 6.
- `start` pulsed in cycles 4 and 9 of the first program → both ignored; the run completes exactly as without them.
- `PC_WIDTH`=2, ROM with no HALT → four ISSUEs (pc 0–3), then `err`=1 and a `done` pulse. A new `start` clears `err`.
- HALT at address 3 with `PC_WIDTH`=2 → `done` pulses, `err` stays 0.
